// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC backplane bus-request arbiter.
//   state_t       : arbiter FSM states
//   DEFAULT_NSLOT : default number of requesting expansion slots
//   INACTIVE_B    : idle level of the active-low bus handshake lines
package cpc_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      GRANT,
      DRAIN,
      GAP
   } state_t;

   localparam int unsigned DEFAULT_NSLOT = 4;
   localparam logic        INACTIVE_B    = 1'b1;

endpackage

// File: rtl/cpc_rr_picker.sv
// Combinational round-robin priority picker.
//   i_eligible : per-slot eligible vector
//   i_last     : index of the previous winner
//   o_winner_c : first eligible index searching from i_last+1 with wrap
//   o_any_c    : high when any slot is eligible
module cpc_rr_picker
   import cpc_bus_pkg::*;
#(
   parameter  int unsigned NSLOT = DEFAULT_NSLOT,
   localparam int unsigned IW    = $clog2(NSLOT)
) (
   input  logic [NSLOT-1:0] i_eligible,
   input  logic [IW-1:0]    i_last,
   output logic [IW-1:0]    o_winner_c,
   output logic             o_any_c
);

   // Walk the slots starting just after the last winner; first hit wins.
   always_comb begin
      int unsigned w_idx;
      o_winner_c = '0;
      o_any_c    = 1'b0;
      w_idx      = 0;
      for (int unsigned k = 1; k <= NSLOT; k++) begin
         w_idx = (32'(i_last) + k) % NSLOT;
         if (!o_any_c && i_eligible[IW'(w_idx)]) begin
            o_any_c    = 1'b1;
            o_winner_c = IW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/cpc_busrq_arbiter.sv
// Shares the Z80 BUSRQ_B/BUSACK_B pair between NSLOT DMA expansion cards,
// round-robin, with a per-grant hold limit and a CPU run gap between grants.
//   CLK, RESET     : bus clock, asynchronous active-high reset
//   EN             : allows new grants to start
//   SLOT_BUSRQ_B   : per-slot request (active low, asynchronous)
//   SLOT_BUSACK_B  : per-slot acknowledge (active low, one-cold)
//   BUSRQ_B        : request to the Z80 (active low)
//   BUSACK_B       : acknowledge from the Z80 (active low, synchronous)
//   GRANT_VALID    : a slot currently owns the bus
//   GRANT_ID       : current/last winner
//   TIMEOUT        : one-cycle pulse when a grant is revoked by the hold limit
module cpc_busrq_arbiter
   import cpc_bus_pkg::*;
#(
   parameter  int unsigned NSLOT      = DEFAULT_NSLOT,
   parameter  int unsigned HOLD_LIMIT = 1024,
   parameter  int unsigned CPU_GAP    = 4,
   parameter  int unsigned GW         = 11,
   localparam int unsigned IW         = $clog2(NSLOT)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic [NSLOT-1:0] SLOT_BUSRQ_B,
   output logic [NSLOT-1:0] SLOT_BUSACK_B,
   output logic             BUSRQ_B,
   input  logic             BUSACK_B,
   output logic             GRANT_VALID,
   output logic [IW-1:0]    GRANT_ID,
   output logic             TIMEOUT
);

   state_t           r_state,         w_state_nxt;
   logic [NSLOT-1:0] r_sync1,         r_sync2;
   logic [NSLOT-1:0] r_lockout,       w_lockout_nxt;
   logic [IW-1:0]    r_last,          w_last_nxt;
   logic [GW-1:0]    r_hold,          w_hold_nxt;
   logic [GW-1:0]    r_gap,           w_gap_nxt;
   logic             r_busrq_b,       w_busrq_b_nxt;
   logic [NSLOT-1:0] r_slot_ack_b,    w_slot_ack_b_nxt;
   logic             r_grant_valid,   w_grant_valid_nxt;
   logic [IW-1:0]    r_grant_id,      w_grant_id_nxt;
   logic             r_timeout,       w_timeout_nxt;

   logic [NSLOT-1:0] w_req;
   logic [NSLOT-1:0] w_eligible;
   logic [IW-1:0]    w_winner;
   logic             w_any;
   logic             w_limit_hit;

   assign w_req       = ~r_sync2;
   assign w_eligible  = w_req & ~r_lockout;
   assign w_limit_hit = (HOLD_LIMIT != 0) && (r_hold == GW'(HOLD_LIMIT - 1));

   cpc_rr_picker #(
      .NSLOT (NSLOT)
   ) u_picker (
      .i_eligible (w_eligible),
      .i_last     (r_last),
      .o_winner_c (w_winner),
      .o_any_c    (w_any)
   );

   // State, synchroniser and registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state       <= IDLE;
         r_sync1       <= {NSLOT{INACTIVE_B}};
         r_sync2       <= {NSLOT{INACTIVE_B}};
         r_lockout     <= '0;
         r_last        <= IW'(NSLOT - 1);
         r_hold        <= '0;
         r_gap         <= '0;
         r_busrq_b     <= INACTIVE_B;
         r_slot_ack_b  <= {NSLOT{INACTIVE_B}};
         r_grant_valid <= 1'b0;
         r_grant_id    <= '0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_sync1       <= SLOT_BUSRQ_B;
         r_sync2       <= r_sync1;
         r_lockout     <= w_lockout_nxt;
         r_last        <= w_last_nxt;
         r_hold        <= w_hold_nxt;
         r_gap         <= w_gap_nxt;
         r_busrq_b     <= w_busrq_b_nxt;
         r_slot_ack_b  <= w_slot_ack_b_nxt;
         r_grant_valid <= w_grant_valid_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_timeout     <= w_timeout_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt       = r_state;
      w_last_nxt        = r_last;
      w_hold_nxt        = r_hold;
      w_gap_nxt         = r_gap;
      w_busrq_b_nxt     = r_busrq_b;
      w_slot_ack_b_nxt  = r_slot_ack_b;
      w_grant_valid_nxt = r_grant_valid;
      w_grant_id_nxt    = r_grant_id;
      w_timeout_nxt     = 1'b0;
      // A locked-out slot is forgiven once its request is seen released.
      w_lockout_nxt     = r_lockout & ~r_sync2;

      case (r_state)
         IDLE: begin
            if (EN && w_any) begin
               w_grant_id_nxt = w_winner;
               w_last_nxt     = w_winner;
               w_busrq_b_nxt  = ~INACTIVE_B;
               w_state_nxt    = REQ;
            end
         end
         REQ: begin
            if (!w_req[r_grant_id]) begin
               w_busrq_b_nxt = INACTIVE_B;
               w_state_nxt   = DRAIN;
            end else if (!BUSACK_B) begin
               w_slot_ack_b_nxt             = {NSLOT{INACTIVE_B}};
               w_slot_ack_b_nxt[r_grant_id] = ~INACTIVE_B;
               w_grant_valid_nxt            = 1'b1;
               w_hold_nxt                   = '0;
               w_state_nxt                  = GRANT;
            end
         end
         GRANT: begin
            w_hold_nxt = r_hold + GW'(1);
            if (!w_req[r_grant_id] || w_limit_hit) begin
               w_slot_ack_b_nxt  = {NSLOT{INACTIVE_B}};
               w_grant_valid_nxt = 1'b0;
               w_busrq_b_nxt     = INACTIVE_B;
               w_state_nxt       = DRAIN;
               // A slot that drops its request on the limit cycle is a normal release.
               if (w_req[r_grant_id]) begin
                  w_timeout_nxt             = 1'b1;
                  w_lockout_nxt[r_grant_id] = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (BUSACK_B) begin
               if (CPU_GAP == 0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_gap_nxt   = GW'(CPU_GAP);
                  w_state_nxt = GAP;
               end
            end
         end
         GAP: begin
            w_gap_nxt = r_gap - GW'(1);
            if (r_gap <= GW'(1)) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign SLOT_BUSACK_B = r_slot_ack_b;
   assign BUSRQ_B       = r_busrq_b;
   assign GRANT_VALID   = r_grant_valid;
   assign GRANT_ID      = r_grant_id;
   assign TIMEOUT       = r_timeout;

endmodule

// File: tb/tb_cpc_busrq_arbiter.sv
// Directed bench for cpc_busrq_arbiter (NSLOT=4, HOLD_LIMIT=16, CPU_GAP=4).
// The CPU model echoes BUSRQ_B onto BUSACK_B two clocks later; expected
// winners are queued when requests are driven and checked on each new grant.
module tb_cpc_busrq_arbiter;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       EN = 1'b1;
   logic [3:0] SLOT_BUSRQ_B = 4'hF;
   logic [3:0] SLOT_BUSACK_B;
   logic       BUSRQ_B;
   logic       BUSACK_B;
   logic       GRANT_VALID;
   logic [1:0] GRANT_ID;
   logic       TIMEOUT;

   logic cpu_d1 = 1'b1;
   logic cpu_d2 = 1'b1;
   logic cpu_stall = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int n_timeouts = 0;
   int exp_q[$];
   logic prev_gv = 1'b0;

   cpc_busrq_arbiter #(
      .NSLOT      (4),
      .HOLD_LIMIT (16),
      .CPU_GAP    (4),
      .GW         (11)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .EN            (EN),
      .SLOT_BUSRQ_B  (SLOT_BUSRQ_B),
      .SLOT_BUSACK_B (SLOT_BUSACK_B),
      .BUSRQ_B       (BUSRQ_B),
      .BUSACK_B      (BUSACK_B),
      .GRANT_VALID   (GRANT_VALID),
      .GRANT_ID      (GRANT_ID),
      .TIMEOUT       (TIMEOUT)
   );

   always #5 CLK = ~CLK;

   // CPU: acknowledges (and releases) two clocks after BUSRQ_B changes.
   always @(posedge CLK) begin
      cpu_d1 <= BUSRQ_B;
      cpu_d2 <= cpu_d1;
   end
   assign BUSACK_B = cpu_stall ? 1'b1 : cpu_d2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Invariants and scoreboard, sampled on the falling edge.
   always @(negedge CLK) begin
      logic [3:0] exp_ack;
      int e;
      if (RESET) begin
         prev_gv = 1'b0;
      end else begin
         check("ack_onehot", 32'($countones(~SLOT_BUSACK_B) <= 1), 32'd1);
         check("ack_while_busrq_high", 32'(BUSRQ_B && (SLOT_BUSACK_B != 4'hF)), 32'd0);
         if (TIMEOUT) n_timeouts++;
         if (GRANT_VALID && !prev_gv) begin
            check("grant_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               exp_ack = ~(4'(1) << e);
               check("grant_id", 32'(GRANT_ID), 32'(e));
               check("grant_ack", 32'(SLOT_BUSACK_B), 32'(exp_ack));
            end
         end
         prev_gv = GRANT_VALID;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_gv(input logic val, input string tag);
      int n = 0;
      while (GRANT_VALID !== val && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check(tag, 32'(GRANT_VALID), 32'(val));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] acc_ack;
      logic acc_gv;

      // Reset values
      cyc(2);
      check("rst_busrq", 32'(BUSRQ_B), 32'd1);
      check("rst_ack", 32'(SLOT_BUSACK_B), 32'hF);
      check("rst_gv", 32'(GRANT_VALID), 32'd0);
      check("rst_gid", 32'(GRANT_ID), 32'd0);
      check("rst_timeout", 32'(TIMEOUT), 32'd0);
      RESET = 1'b0;
      cyc(2);

      // Single request: latency, acknowledge, release and CPU gap
      SLOT_BUSRQ_B = 4'b1110;
      exp_q.push_back(0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rq_lat_edge2", 32'(BUSRQ_B), 32'd1);
      cyc(1);
      check("rq_lat_edge3", 32'(BUSRQ_B), 32'd0);
      n = 0;
      while (BUSACK_B !== 1'b0 && n < 20) begin
         cyc(1);
         n++;
      end
      check("cpu_ack_seen", 32'(BUSACK_B), 32'd0);
      check("ack_before_edge", 32'(SLOT_BUSACK_B), 32'hF);
      cyc(1);
      check("ack_after_edge", 32'(SLOT_BUSACK_B), 32'hE);
      check("gv_after_edge", 32'(GRANT_VALID), 32'd1);
      cyc(4);
      SLOT_BUSRQ_B = 4'b1111;
      cyc(2);
      check("rel_lat_edge2", 32'(BUSRQ_B), 32'd0);
      cyc(1);
      check("rel_lat_edge3", 32'(BUSRQ_B), 32'd1);
      check("rel_ack", 32'(SLOT_BUSACK_B), 32'hF);
      check("rel_gv", 32'(GRANT_VALID), 32'd0);
      // Re-request at once: 2 edges CPU release, DRAIN, 4 GAP, IDLE decision
      SLOT_BUSRQ_B = 4'b1110;
      exp_q.push_back(0);
      n = 0;
      while (BUSRQ_B !== 1'b0 && n < 30) begin
         cyc(1);
         n++;
      end
      check("gap_edges_to_rerequest", 32'(n), 32'd8);
      wait_gv(1'b1, "regrant_gv");
      SLOT_BUSRQ_B = 4'b1111;
      wait_gv(1'b0, "regrant_rel");
      cyc(12);

      // Round-robin from a fresh reset: 0,1,2,3,0
      RESET = 1'b1;
      cyc(1);
      RESET = 1'b0;
      SLOT_BUSRQ_B = 4'b0000;
      for (int k = 0; k < 5; k++) exp_q.push_back(order[k]);
      for (int k = 0; k < 5; k++) begin
         wait_gv(1'b1, "rr_gv");
         cyc(10);
         if (k == 4) SLOT_BUSRQ_B = 4'hF;
         else SLOT_BUSRQ_B[order[k]] = 1'b1;
         wait_gv(1'b0, "rr_rel");
         cyc(2);
         if (k < 4) SLOT_BUSRQ_B[order[k]] = 1'b0;
      end
      cyc(15);

      // Hold-limit timeout on slot 2, slot 3 served while slot 2 is locked out
      SLOT_BUSRQ_B = 4'b1011;
      exp_q.push_back(2);
      wait_gv(1'b1, "to_gv");
      SLOT_BUSRQ_B = 4'b0011;
      exp_q.push_back(3);
      n = 0;
      for (int k = 0; k < 15; k++) begin
         cyc(1);
         if (GRANT_VALID && !TIMEOUT) n++;
      end
      check("to_hold_cycles", 32'(n), 32'd15);
      cyc(1);
      check("to_pulse", 32'(TIMEOUT), 32'd1);
      check("to_gv_drop", 32'(GRANT_VALID), 32'd0);
      check("to_ack_rel", 32'(SLOT_BUSACK_B), 32'hF);
      cyc(1);
      check("to_pulse_end", 32'(TIMEOUT), 32'd0);
      wait_gv(1'b1, "to_slot3_gv");
      cyc(5);
      SLOT_BUSRQ_B = 4'b1011;
      wait_gv(1'b0, "to_slot3_rel");
      cyc(20);
      check("lockout_busrq", 32'(BUSRQ_B), 32'd1);
      check("lockout_gv", 32'(GRANT_VALID), 32'd0);
      SLOT_BUSRQ_B = 4'b1111;
      cyc(4);
      SLOT_BUSRQ_B = 4'b1011;
      exp_q.push_back(2);
      wait_gv(1'b1, "unlock_gv");
      cyc(3);
      SLOT_BUSRQ_B = 4'b1111;
      wait_gv(1'b0, "unlock_rel");
      cyc(12);

      // Abandon: slot 1 withdraws before the CPU acknowledges
      cpu_stall = 1'b1;
      SLOT_BUSRQ_B = 4'b1101;
      n = 0;
      while (BUSRQ_B !== 1'b0 && n < 50) begin
         cyc(1);
         n++;
      end
      check("abandon_rq", 32'(BUSRQ_B), 32'd0);
      SLOT_BUSRQ_B = 4'b1111;
      acc_ack = 4'hF;
      acc_gv = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         acc_ack &= SLOT_BUSACK_B;
         acc_gv |= GRANT_VALID;
      end
      check("abandon_busrq_rel", 32'(BUSRQ_B), 32'd1);
      check("abandon_ack", 32'(acc_ack), 32'hF);
      check("abandon_gv", 32'(acc_gv), 32'd0);
      cpu_stall = 1'b0;
      cyc(12);

      // Asynchronous reset in the middle of a grant
      SLOT_BUSRQ_B = 4'b0101;
      exp_q.push_back(3);
      wait_gv(1'b1, "arst_gv");
      cyc(2);
      #2 RESET = 1'b1;
      #1;
      check("arst_busrq", 32'(BUSRQ_B), 32'd1);
      check("arst_ack", 32'(SLOT_BUSACK_B), 32'hF);
      check("arst_gv", 32'(GRANT_VALID), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      exp_q.push_back(1);
      wait_gv(1'b1, "arst_regrant");
      SLOT_BUSRQ_B = 4'b1111;
      wait_gv(1'b0, "arst_rel");
      cyc(12);

      // EN low blocks a pending request; raising it starts the grant next edge
      EN = 1'b0;
      SLOT_BUSRQ_B = 4'b1110;
      cyc(10);
      check("en_low_busrq", 32'(BUSRQ_B), 32'd1);
      EN = 1'b1;
      exp_q.push_back(0);
      cyc(1);
      check("en_rise_busrq", 32'(BUSRQ_B), 32'd0);
      wait_gv(1'b1, "en_gv");
      SLOT_BUSRQ_B = 4'b1111;
      wait_gv(1'b0, "en_rel");
      cyc(12);

      check("timeout_count", 32'(n_timeouts), 32'd1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
